// File: rtl/punc_pkg.sv
// Shared PUnC definitions: requester indices and memory-arbiter state encodings.
package punc_pkg;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DEBUG = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/punc_mem_arbiter_if.sv
// Memory-arbiter bus: per-requester request/response lanes plus the shared memory port.
// master = requesters and memory; slave = the arbiter.
interface punc_mem_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       rdata;
  logic                    busy;
  logic [ID_W-1:0]         gnt_id;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  done, rdata, busy, gnt_id, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output done, rdata, busy, gnt_id, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/punc_arb_picker.sv
// Combinational winner select for the PUnC memory arbiter.
// With PUNC_ARB_RR_EN defined the search starts after ptr; otherwise the highest requesting index wins.
module punc_arb_picker #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
`ifdef PUNC_ARB_RR_EN
  input  logic [ID_W-1:0]  ptr,
`endif
  output logic [ID_W-1:0]  id,
  output logic             valid
);

`ifdef PUNC_ARB_RR_EN
  int cand_s;

  // Walk from the farthest candidate back to ptr+1 so the nearest requester after ptr overwrites last.
  always_comb begin
    id     = {ID_W{1'b0}};
    valid  = 1'b0;
    cand_s = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_s = (int'(ptr) + k) % N_REQ;
      valid  = valid | req[cand_s];
      id     = req[cand_s] ? ID_W'(cand_s) : id;
    end
  end
`else
  // Fixed priority: ascending scan, so the highest requesting index is the final value.
  always_comb begin
    id    = {ID_W{1'b0}};
    valid = |req;
    for (int i = 0; i < N_REQ; i++) begin
      id = req[i] ? ID_W'(i) : id;
    end
  end
`endif

endmodule

// File: rtl/punc_mem_arbiter.sv
// PUnC memory-port arbiter: one access in flight, one-cycle done pulse with read data.
// Define PUNC_ARB_RR_EN for round-robin arbitration; default build is fixed priority (highest index wins).
module punc_mem_arbiter
  import punc_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int N_REQ        = 3,
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  punc_mem_arbiter_if.slave bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(READ_LATENCY - 1);

  arb_state_t         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               we_r;
  logic [N_REQ-1:0]   done_r;
  logic               rd_done_r;
  logic               busy_r;
  logic [ID_W-1:0]    gnt_id_r;
  logic               mem_en_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic [DATA_W-1:0]  rdata_s;

  logic [ID_W-1:0]    pick_id_s;
  logic               pick_valid_s;
  logic               pick_we_s;
  logic [ADDR_W-1:0]  pick_addr_s;
  logic [DATA_W-1:0]  pick_wdata_s;

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] idx);
    id_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

`ifdef PUNC_ARB_RR_EN
  logic [ID_W-1:0] ptr_r;

  // Round-robin pointer remembers the last granted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= ID_W'(N_REQ - 1);
    end else if (state_r == ARB_IDLE && pick_valid_s) begin
      ptr_r <= pick_id_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  punc_arb_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req   (bus.req),
`ifdef PUNC_ARB_RR_EN
    .ptr   (ptr_r),
`endif
    .id    (pick_id_s),
    .valid (pick_valid_s)
  );

  assign pick_we_s    = bus.req_we[pick_id_s];
  assign pick_addr_s  = bus.req_addr[int'(pick_id_s)*ADDR_W +: ADDR_W];
  assign pick_wdata_s = bus.req_wdata[int'(pick_id_s)*DATA_W +: DATA_W];

  // Access FSM: fields are captured at grant so later requester changes cannot disturb the access.
  // done is raised one cycle early so it appears registered in the completion cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ARB_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      we_r        <= 1'b0;
      done_r      <= {N_REQ{1'b0}};
      rd_done_r   <= 1'b0;
      busy_r      <= 1'b0;
      gnt_id_r    <= {ID_W{1'b0}};
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          done_r    <= {N_REQ{1'b0}};
          rd_done_r <= 1'b0;
          if (pick_valid_s) begin
            state_r     <= ARB_ISSUE;
            busy_r      <= 1'b1;
            gnt_id_r    <= pick_id_s;
            we_r        <= pick_we_s;
            mem_en_r    <= 1'b1;
            mem_we_r    <= pick_we_s;
            mem_addr_r  <= pick_addr_s;
            mem_wdata_r <= pick_wdata_s;
            done_r      <= pick_we_s ? id_onehot(pick_id_s) : {N_REQ{1'b0}};
          end else begin
            busy_r <= 1'b0;
          end
        end
        ARB_ISSUE: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          if (we_r) begin
            done_r  <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
            state_r <= ARB_IDLE;
          end else begin
            cnt_r   <= CNT_ONE;
            state_r <= ARB_WAIT;
            if (CNT_LAST == CNT_ONE) begin
              done_r    <= id_onehot(gnt_id_r);
              rd_done_r <= 1'b1;
            end else begin
              done_r    <= {N_REQ{1'b0}};
              rd_done_r <= 1'b0;
            end
          end
        end
        ARB_WAIT: begin
          if (cnt_r == CNT_LAST) begin
            done_r    <= {N_REQ{1'b0}};
            rd_done_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= ARB_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_PRE) begin
              done_r    <= id_onehot(gnt_id_r);
              rd_done_r <= 1'b1;
            end else begin
              done_r    <= {N_REQ{1'b0}};
              rd_done_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= ARB_IDLE;
          done_r    <= {N_REQ{1'b0}};
          rd_done_r <= 1'b0;
          busy_r    <= 1'b0;
          mem_en_r  <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is a straight pass of the memory bus, gated to the read completion cycle.
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    if (rd_done_r) begin
      rdata_s = bus.mem_rdata;
    end else begin
      rdata_s = {DATA_W{1'b0}};
    end
  end

  assign bus.done      = done_r;
  assign bus.rdata     = rdata_s;
  assign bus.busy      = busy_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Scoreboard bench for punc_mem_arbiter with a READ_LATENCY-accurate memory model.
module tb_punc_mem_arbiter;
  localparam int N_REQ  = 3;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RL     = 2;

  typedef struct { int cyc; logic [15:0] addr; logic we; logic [15:0] wdata; } mem_exp_t;
  typedef struct { int cyc; int id; logic rd; logic [15:0] data; } done_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];
  mem_exp_t  m_m;
  done_exp_t d_m;
  logic [15:0] mem [0:65535];
  logic [15:0] pipe [RL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  punc_mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  punc_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Memory: writes land at the edge, read data appears RL cycles after the mem_en cycle
  always @(posedge clk) begin
    if (cyc == 0) begin
      mem[16'h3000] <= 16'h1234;
      mem[16'h5000] <= 16'hA5A5;
      mem[16'h6000] <= 16'h0F0F;
      mem[16'h7000] <= 16'h7777;
      mem[16'h1111] <= 16'hDEAD;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 16'hBAD0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[RL-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes memory or pulses done
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_en) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual=addr %h required=no access", bus.mem_addr);
        end else begin
          m_m = mem_q.pop_front();
          chk("mem_cyc", cyc, m_m.cyc);
          chk("mem_addr", bus.mem_addr, m_m.addr);
          chk("mem_we", bus.mem_we, m_m.we);
          if (m_m.we) chk("mem_wdata", bus.mem_wdata, m_m.wdata);
        end
      end
      if (|bus.done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=%b required=000", bus.done);
        end else begin
          d_m = done_q.pop_front();
          chk("done_vec", bus.done, 32'(1) << d_m.id);
          chk("done_cyc", cyc, d_m.cyc);
          chk("gnt_id", bus.gnt_id, d_m.id);
          chk("busy_at_done", bus.busy, 1);
          if (d_m.rd) chk("rdata", bus.rdata, d_m.data);
        end
      end
    end
  end

  task automatic push_rd(input int id, input logic [15:0] addr, input logic [15:0] data, input int ic);
    mem_q.push_back('{ic, addr, 1'b0, 16'h0000});
    done_q.push_back('{ic + RL, id, 1'b1, data});
  endtask

  task automatic push_wr(input int id, input logic [15:0] addr, input logic [15:0] wdata, input int ic);
    mem_q.push_back('{ic, addr, 1'b1, wdata});
    done_q.push_back('{ic, id, 1'b0, 16'h0000});
  endtask

  task automatic set_req(input int id, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.req_we[id] = we;
    bus.req_addr[id*ADDR_W +: ADDR_W] = addr;
    bus.req_wdata[id*DATA_W +: DATA_W] = wdata;
    bus.req[id] = 1'b1;
  endtask

  task automatic wait_done(input int id, input string name);
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      seen = bus.done[id];
      n++;
    end
    chk(name, 32'(seen), 1);
  endtask

  task automatic wait_n_done(input int cnt, input string name);
    int seen = 0;
    int k = 0;
    while (seen < cnt && k < 80) begin
      @(negedge clk);
      if (|bus.done) seen++;
      k++;
    end
    chk(name, seen, cnt);
  endtask

  // Issue one access from an idle arbiter, wait for its done, then release req
  task automatic single(input int id, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd, input string name);
    int c;
    @(posedge clk); #1;
    c = cyc;
    set_req(id, we, addr, wdata);
    if (we) push_wr(id, addr, wdata, c + 1);
    else    push_rd(id, addr, exp_rd, c + 1);
    wait_done(id, name);
    @(posedge clk); #1;
    bus.req[id] = 1'b0;
  endtask

  initial begin
    int c;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_gnt_id", bus.gnt_id, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;

    // Contention with all three reads held
    @(posedge clk); #1;
    c = cyc;
    set_req(0, 1'b0, 16'h3000, 16'h0000);
    set_req(1, 1'b0, 16'h5000, 16'h0000);
    set_req(2, 1'b0, 16'h7000, 16'h0000);
`ifdef PUNC_ARB_RR_EN
    push_rd(0, 16'h3000, 16'h1234, c + 1);
    push_rd(1, 16'h5000, 16'hA5A5, c + 5);
    push_rd(2, 16'h7000, 16'h7777, c + 9);
    push_rd(0, 16'h3000, 16'h1234, c + 13);
    push_rd(1, 16'h5000, 16'hA5A5, c + 17);
    wait_n_done(5, "rr_grants");
`else
    push_rd(2, 16'h7000, 16'h7777, c + 1);
    push_rd(2, 16'h7000, 16'h7777, c + 5);
    push_rd(2, 16'h7000, 16'h7777, c + 9);
    wait_n_done(3, "fixed_grants");
`endif
    @(posedge clk); #1;
    bus.req = '0;

    single(0, 1'b0, 16'h3000, 16'h0000, 16'h1234, "t1_read");
    single(1, 1'b1, 16'h4000, 16'hBEEF, 16'h0000, "t2_write");
    single(0, 1'b0, 16'h4000, 16'h0000, 16'hBEEF, "t2_readback");
    single(2, 1'b1, 16'h3000, 16'h5A5A, 16'h0000, "dbg_write");
    single(1, 1'b0, 16'h3000, 16'h0000, 16'h5A5A, "data_read");

    // Reset while the read is in WAIT: abandoned with no done, then re-arbitrated
    @(posedge clk); #1;
    c = cyc;
    set_req(0, 1'b0, 16'h6000, 16'h0000);
    mem_q.push_back('{c + 1, 16'h6000, 1'b0, 16'h0000});
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_mem_en", bus.mem_en, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    c = cyc;
    push_rd(0, 16'h6000, 16'h0F0F, c + 1);
    wait_done(0, "t5_rearb");
    @(posedge clk); #1;
    bus.req[0] = 1'b0;

    // Request dropped and address changed right after grant
    @(posedge clk); #1;
    c = cyc;
    set_req(0, 1'b0, 16'h5000, 16'h0000);
    push_rd(0, 16'h5000, 16'hA5A5, c + 1);
    @(posedge clk); #1;
    bus.req[0] = 1'b0;
    bus.req_addr[0 +: ADDR_W] = 16'h1111;
    wait_done(0, "t6_done");

    repeat (8) @(negedge clk);
    chk("mem_q_empty", mem_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
